// File: rtl/dma_copy_engine_if.sv
// Data-memory port shared between the copy engine and the MEM stage.
// The master side is the initiator (copy engine). The slave side is the
// arbiter/memory, which supplies the grant and the combinational read data.
interface dma_copy_engine_if #(
    parameter int ADDRESS_LINE = 8
);
    logic                    mem_grant;
    logic [7:0]              mem_read_data;
    logic [ADDRESS_LINE-1:0] mem_address;
    logic [7:0]              mem_write_data;
    logic                    mem_write;
    logic                    mem_read;
    logic                    mem_req;

    modport master (
        input  mem_grant, mem_read_data,
        output mem_address, mem_write_data, mem_write, mem_read, mem_req
    );

    modport slave (
        output mem_grant, mem_read_data,
        input  mem_address, mem_write_data, mem_write, mem_read, mem_req
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Byte-wise memory-to-memory copy engine. It alternates READ/WRITE cycles
// on the shared data-memory port and copies in ascending address order.
// Any cycle without a grant stalls the engine in place.
module dma_copy_engine #(
    parameter int ADDRESS_LINE = 8,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_LINE-1:0] src_addr,
    input  logic [ADDRESS_LINE-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]    length,
    dma_copy_engine_if.master       bus,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    remaining
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                  state, state_next;
    logic [ADDRESS_LINE-1:0] src_ptr, dst_ptr;
    logic [7:0]              data_buf;
    logic [LEN_WIDTH-1:0]    rem_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Pointers, byte buffer and count; these only move on granted cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            data_buf <= '0;
            rem_q    <= '0;
        end else begin
            case (state)
                IDLE: if (start && length != '0) begin
                    src_ptr <= src_addr;
                    dst_ptr <= dst_addr;
                    rem_q   <= length;
                end
                READ: if (bus.mem_grant) data_buf <= bus.mem_read_data;
                WRITE: if (bus.mem_grant) begin
                    // Pointers wrap naturally at the address width
                    src_ptr <= src_ptr + ADDRESS_LINE'(1);
                    dst_ptr <= dst_ptr + ADDRESS_LINE'(1);
                    rem_q   <= rem_q - LEN_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Next state and memory strobes; address/data are parked at 0 when no strobe
    always_comb begin
        state_next         = state;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state)
            IDLE: if (start) state_next = (length == '0) ? DONE : READ;
            READ: if (bus.mem_grant) begin
                bus.mem_read    = 1'b1;
                bus.mem_address = src_ptr;
                state_next      = WRITE;
            end
            WRITE: if (bus.mem_grant) begin
                bus.mem_write      = 1'b1;
                bus.mem_address    = dst_ptr;
                bus.mem_write_data = data_buf;
                state_next         = (rem_q == LEN_WIDTH'(1)) ? DONE : READ;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state == READ) || (state == WRITE);
    assign bus.mem_req = busy;
    assign done        = (state == DONE);
    assign remaining   = rem_q;
endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a behavioural 256-byte data memory.
module tb_dma_copy_engine;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done;
    logic [LW-1:0] remaining;

    dma_copy_engine_if #(.ADDRESS_LINE(AW)) bus();

    dma_copy_engine #(.ADDRESS_LINE(AW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .bus(bus), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:255];
    assign bus.mem_read_data = mem[bus.mem_address];

    int vectors = 0;
    int miscompares = 0;

    // Per-run observations
    int         cyc = 0;
    int         start_cyc;
    int         n_rd, n_wr, n_busy, n_both, n_ungr, n_idle_drive, n_done, done_cyc;
    logic       busy_at_done;
    logic [7:0] rem_first;
    logic [7:0] rd_addr [$];
    logic       chk_zero, zero_ok;

    task automatic clear_obs();
        n_rd = 0; n_wr = 0; n_busy = 0; n_both = 0; n_ungr = 0;
        n_idle_drive = 0; n_done = 0; done_cyc = -1; busy_at_done = 1'b0;
        rd_addr.delete(); chk_zero = 1'b0; zero_ok = 1'b0; rem_first = 8'hxx;
    endtask

    task automatic mem_init();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[1] = 8'h05;
        mem[2] = 8'h06;
    endtask

    // One clock: called just after a negedge with inputs driven; samples,
    // commits a pending memory write at the posedge, returns after the next negedge.
    task automatic tick();
        logic       w;
        logic [7:0] a, d;
        #1;
        if (bus.mem_read) begin n_rd++; rd_addr.push_back(bus.mem_address); end
        if (bus.mem_write) n_wr++;
        if (bus.mem_read && bus.mem_write) n_both++;
        if (!bus.mem_grant && (bus.mem_read || bus.mem_write)) n_ungr++;
        if (!bus.mem_write && bus.mem_write_data != 8'h00) n_idle_drive++;
        if (!bus.mem_read && !bus.mem_write && bus.mem_address != 8'h00) n_idle_drive++;
        if (busy) n_busy++;
        if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
        if (chk_zero) begin
            zero_ok = !busy && !done && remaining == 8'h00 && !bus.mem_read &&
                      !bus.mem_write && !bus.mem_req && bus.mem_address == 8'h00 &&
                      bus.mem_write_data == 8'h00;
            chk_zero = 1'b0;
        end
        w = bus.mem_write; a = bus.mem_address; d = bus.mem_write_data;
        @(posedge clock);
        if (w) mem[a] = d;
        cyc++;
        @(negedge clock);
    endtask

    // Launch a copy; grant low for the first 'ungrant' cycles after start,
    // optionally re-pulse start at offset 'repulse', optionally reset the
    // cycle after the first write.
    task automatic run_copy(input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] len, input int ungrant,
                            input int repulse, input bit rst_wr);
        bit rst_fired = 1'b0;
        clear_obs();
        start = 1'b1; src_addr = src; dst_addr = dst; length = len;
        bus.mem_grant = (ungrant == 0);
        start_cyc = cyc;
        tick();
        start = 1'b0; src_addr = 8'h77; dst_addr = 8'h99; length = 8'h33;
        for (int k = 1; k < 40; k++) begin
            bus.mem_grant = (k > ungrant);
            if (repulse != 0 && k == repulse) begin
                start = 1'b1; src_addr = 8'd50; dst_addr = 8'd60; length = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (rst_fired && reset) chk_zero = 1'b0;
            if (rst_wr && !rst_fired && n_wr == 1) begin
                reset = 1'b1; rst_fired = 1'b1;
            end else begin
                if (reset && rst_fired) chk_zero = 1'b1;
                reset = 1'b0;
            end
            if (k == 1) rem_first = remaining;
            tick();
            if (!rst_wr && n_done > 0) break;
        end
        start = 1'b0; reset = 1'b0; bus.mem_grant = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus.mem_grant = 1'b1;
        clear_obs();
        tick(); tick();
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done); end
        vectors++; if (remaining !== 8'h00) begin miscompares++; $display("FAIL reset_remaining got %h expected 00", remaining); end
        vectors++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_strobes got rd=%b wr=%b req=%b expected 0", bus.mem_read, bus.mem_write, bus.mem_req); end
        vectors++; if (bus.mem_address !== 8'h00 || bus.mem_write_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_bus got addr=%h data=%h expected 00", bus.mem_address, bus.mem_write_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        mem_init();
        run_copy(8'd1, 8'd10, 8'd2, 0, 0, 1'b0);
        vectors++; if (mem[10] !== 8'h05) begin miscompares++; $display("FAIL basic_mem10 got %h expected 05", mem[10]); end
        vectors++; if (mem[11] !== 8'h06) begin miscompares++; $display("FAIL basic_mem11 got %h expected 06", mem[11]); end
        vectors++; if (done_cyc !== start_cyc + 5) begin miscompares++; $display("FAIL basic_done_cycle got %0d expected %0d", done_cyc - start_cyc, 5); end
        vectors++; if (n_rd !== 2 || n_wr !== 2) begin miscompares++; $display("FAIL basic_strobe_count got rd=%0d wr=%0d expected 2/2", n_rd, n_wr); end
        vectors++; if (n_busy !== 4 || busy_at_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy got cycles=%0d at_done=%b expected 4/0", n_busy, busy_at_done); end
        vectors++; if (rem_first !== 8'd2) begin miscompares++; $display("FAIL basic_remaining_load got %0d expected 2", rem_first); end
        vectors++; if (remaining !== 8'd0) begin miscompares++; $display("FAIL basic_remaining_end got %0d expected 0", remaining); end
        vectors++; if (n_both !== 0 || n_idle_drive !== 0) begin miscompares++; $display("FAIL basic_bus_hygiene got both=%0d idle_drive=%0d expected 0/0", n_both, n_idle_drive); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL basic_done_pulses got %0d expected 1", n_done); end
    endtask

    task automatic test_zero_length();
        mem_init();
        run_copy(8'd1, 8'd10, 8'd0, 0, 0, 1'b0);
        vectors++; if (done_cyc !== start_cyc + 1) begin miscompares++; $display("FAIL zero_done_cycle got %0d expected 1", done_cyc - start_cyc); end
        vectors++; if (n_busy !== 0) begin miscompares++; $display("FAIL zero_busy got %0d expected 0", n_busy); end
        vectors++; if (n_rd !== 0 || n_wr !== 0) begin miscompares++; $display("FAIL zero_strobes got rd=%0d wr=%0d expected 0/0", n_rd, n_wr); end
        vectors++; if (mem[10] !== 8'h00) begin miscompares++; $display("FAIL zero_mem10 got %h expected 00", mem[10]); end
    endtask

    task automatic test_ungranted();
        mem_init();
        run_copy(8'd1, 8'd10, 8'd2, 3, 0, 1'b0);
        vectors++; if (done_cyc !== start_cyc + 8) begin miscompares++; $display("FAIL stall_done_cycle got %0d expected 8", done_cyc - start_cyc); end
        vectors++; if (n_ungr !== 0) begin miscompares++; $display("FAIL stall_strobes got %0d expected 0", n_ungr); end
        vectors++; if (n_idle_drive !== 0) begin miscompares++; $display("FAIL stall_idle_drive got %0d expected 0", n_idle_drive); end
        vectors++; if (mem[10] !== 8'h05 || mem[11] !== 8'h06) begin miscompares++; $display("FAIL stall_data got %h %h expected 05 06", mem[10], mem[11]); end
        vectors++; if (n_rd !== 2 || n_wr !== 2) begin miscompares++; $display("FAIL stall_strobe_count got rd=%0d wr=%0d expected 2/2", n_rd, n_wr); end
    endtask

    task automatic test_wrap();
        mem_init();
        mem[255] = 8'hAA;
        mem[0]   = 8'h55;
        run_copy(8'hFF, 8'h20, 8'd2, 0, 0, 1'b0);
        vectors++; if (mem[8'h20] !== 8'hAA || mem[8'h21] !== 8'h55) begin miscompares++; $display("FAIL wrap_data got %h %h expected aa 55", mem[8'h20], mem[8'h21]); end
        vectors++; if (rd_addr.size() !== 2) begin miscompares++; $display("FAIL wrap_read_count got %0d expected 2", rd_addr.size()); end
        else begin
            vectors++; if (rd_addr[0] !== 8'hFF || rd_addr[1] !== 8'h00) begin miscompares++; $display("FAIL wrap_read_addr got %h %h expected ff 00", rd_addr[0], rd_addr[1]); end
        end
    endtask

    task automatic test_overlap();
        mem_init();
        run_copy(8'd1, 8'd2, 8'd3, 0, 0, 1'b0);
        vectors++; if (mem[2] !== 8'h05 || mem[3] !== 8'h05 || mem[4] !== 8'h05) begin
            miscompares++; $display("FAIL overlap_data got %h %h %h expected 05 05 05", mem[2], mem[3], mem[4]); end
        vectors++; if (done_cyc !== start_cyc + 7) begin miscompares++; $display("FAIL overlap_done_cycle got %0d expected 7", done_cyc - start_cyc); end
    endtask

    task automatic test_back_to_back();
        mem_init();
        run_copy(8'd1, 8'd10, 8'd2, 0, 2, 1'b0);
        vectors++; if (mem[10] !== 8'h05 || mem[11] !== 8'h06) begin miscompares++; $display("FAIL repulse_data got %h %h expected 05 06", mem[10], mem[11]); end
        vectors++; if (done_cyc !== start_cyc + 5 || n_done !== 1) begin miscompares++; $display("FAIL repulse_done got cycle=%0d pulses=%0d expected 5/1", done_cyc - start_cyc, n_done); end
        vectors++; if (n_wr !== 2 || mem[60] !== 8'h00) begin miscompares++; $display("FAIL repulse_writes got wr=%0d mem60=%h expected 2/00", n_wr, mem[60]); end
    endtask

    task automatic test_reset_mid_copy();
        mem_init();
        run_copy(8'd1, 8'd30, 8'd2, 0, 0, 1'b1);
        vectors++; if (mem[30] !== 8'h05 || mem[31] !== 8'h00) begin miscompares++; $display("FAIL midreset_data got %h %h expected 05 00", mem[30], mem[31]); end
        vectors++; if (n_wr !== 1) begin miscompares++; $display("FAIL midreset_writes got %0d expected 1", n_wr); end
        vectors++; if (zero_ok !== 1'b1) begin miscompares++; $display("FAIL midreset_outputs got %b expected 1", zero_ok); end
        vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL midreset_done got %0d expected 0", n_done); end
    endtask

    initial begin
        bus.mem_grant = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic();
        test_zero_length();
        test_ungranted();
        test_wrap();
        test_overlap();
        test_back_to_back();
        test_reset_mid_copy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- Memory-to-memory copy engine; the initiator side of the data-memory port (address, write_data, mem_write, mem_read, read_data).
- Copies a block of bytes from a source address range to a destination range in the 8-bit data memory.
- Shares the memory port with the MEM pipeline stage through an external arbiter grant.
- Memory reads are combinational. Memory writes commit on the clock edge.

Parameters:
- ADDRESS_LINE, 8, width of memory addresses and pointers.
- LEN_WIDTH, 8, width of the byte-count field.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; ignored unless the engine is in IDLE.
- src_addr  in  ADDRESS_LINE  first source byte address, sampled with start.
- dst_addr  in  ADDRESS_LINE  first destination byte address, sampled with start.
- length  in  LEN_WIDTH  number of bytes to copy, sampled with start; 0 is legal.
- mem_grant  in  1  arbiter grants the memory port to this block this cycle.
- mem_read_data  in  8  combinational read data from data memory.
- mem_address  out  ADDRESS_LINE  address driven to data memory.
- mem_write_data  out  8  byte driven to data memory.
- mem_write  out  1  write strobe.
- mem_read  out  1  read strobe.
- mem_req  out  1  requests the port from the arbiter; high in READ and WRITE.
- busy  out  1  high in READ and WRITE.
- done  out  1  one-cycle completion pulse.
- remaining  out  LEN_WIDTH  bytes not yet written.

Behaviour:
- Reset: state=IDLE; all outputs 0; internal src_ptr, dst_ptr, buf, remaining cleared.
- States: IDLE, READ, WRITE, DONE (registered).
- IDLE:
  - start=1 and length!=0: load src_ptr, dst_ptr and remaining=length; go to READ.
  - start=1 and length=0: go to DONE; no memory strobes are ever issued.
  - start=0: stay in IDLE.
- READ:
  - mem_read = mem_grant; mem_address = src_ptr when granted. Both are combinational from state and mem_grant.
  - On a granted edge: buf <= mem_read_data; go to WRITE.
  - Ungranted: all mem_* strobes are 0; stay in READ.
- WRITE:
  - mem_write = mem_grant; mem_address = dst_ptr; mem_write_data = buf when granted.
  - On a granted edge: src_ptr+1, dst_ptr+1, remaining-1.
  - Next state is DONE if remaining was 1, otherwise READ.
  - Ungranted: hold state and all registers.
- DONE: done=1 for exactly one cycle; then go to IDLE.
- Idle drive: mem_address and mem_write_data are 0 whenever the corresponding strobe is 0.
- Pointer arithmetic: pointers wrap modulo 2^ADDRESS_LINE (0xFF+1 = 0x00 at default width). No error is flagged.
- Overlap: the copy is always ascending, byte by byte. A destination overlapping above the source replicates bytes; this is defined behaviour and not an error.
- start while not IDLE (READ, WRITE or DONE) is ignored. The new src_addr/dst_addr/length are not sampled.
- Latency, with grant held high and start sampled at edge T:
  - busy from cycle T+1 through T+2L.
  - done pulse in cycle T+2L+1, with busy=0 in that cycle.
  - L=0: done in cycle T+1.
  - Each ungranted cycle adds exactly one cycle of delay.
- Reset mid-copy: returns to IDLE on the next edge and clears all outputs. Bytes already written remain in memory. No done pulse is issued.
- Never asserts mem_read and mem_write in the same cycle.

Test Plan:
- Data memory after reset holds mem[1]=5, mem[2]=6. Start with src=1, dst=10, len=2, grant=1 -> writes mem[10]=5, mem[11]=6. done in cycle T+5. Exactly 2 mem_read and 2 mem_write cycles.
- len=0 -> done in cycle T+1. busy never high. mem_read and mem_write never asserted.
- Copy src=1, dst=10, len=2 with mem_grant held low for 3 cycles while in READ -> no mem strobes during those cycles. done moves to T+8. Data matches the first scenario.
- Wrap: preload mem[0xFF]=0xAA and mem[0x00]=0x55; src=0xFF, dst=0x20, len=2 -> mem[0x20]=0xAA, mem[0x21]=0x55. Read addresses are 0xFF then 0x00.
- Overlap: src=1, dst=2, len=3 from reset contents -> mem[2]=5, mem[3]=5, mem[4]=5.
- start re-pulsed while busy is ignored and the original copy completes unchanged. In a second run, assert reset one cycle after the first granted write -> only dst byte 0 is written, all outputs are 0 next cycle, and no done pulse occurs.
